// File: rtl/ballot_session_controller_if.sv
// Signal bundle between the officer/button front end and the ballot session controller.
interface ballot_session_controller_if;
   logic       mode;
   logic       officer_arm;
   logic [3:0] valid_vote;
   logic [3:0] cand_grant;
   logic       voter_ready;
   logic       busy;
   logic       reject;
   logic [7:0] total_votes;
   logic [1:0] disp_sel;

   modport master (
      output mode, officer_arm, valid_vote,
      input  cand_grant, voter_ready, busy, reject, total_votes, disp_sel
   );

   modport slave (
      input  mode, officer_arm, valid_vote,
      output cand_grant, voter_ready, busy, reject, total_votes, disp_sel
   );
endinterface

// File: rtl/ballot_session_controller.sv
// One-voter-per-arm session sequencer: grants a single vote, locks out, and scans
// the candidate index for the result display.
module ballot_session_controller #(
   parameter int LOCK_CYCLES = 16,
   parameter int DISP_CYCLES = 8,
   parameter int ARM_TIMEOUT = 64
) (
   input logic                        clock,
   input logic                        reset,
   ballot_session_controller_if.slave bus
);
   localparam int MAX_LD  = (LOCK_CYCLES > DISP_CYCLES) ? LOCK_CYCLES : DISP_CYCLES;
   localparam int CNT_MAX = (MAX_LD > ARM_TIMEOUT) ? MAX_LD : ARM_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
   localparam logic [CW-1:0] DISP_LAST = CW'(DISP_CYCLES - 1);
   localparam logic [CW-1:0] ARM_LAST  = CW'(ARM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_GRANT, S_LOCKOUT, S_RESULTS
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    grant_q, grant_d;
   logic          reject_q, reject_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic [7:0]    total_q, total_d;
   logic [1:0]    disp_q, disp_d;
   logic          single_press;
   logic          multi_press;

   // x & (x-1) clears the lowest set bit, so a non-zero remainder means two or more presses
   assign multi_press  = (bus.valid_vote & (bus.valid_vote - 4'd1)) != 4'd0;
   assign single_press = (bus.valid_vote != 4'd0) && !multi_press;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      grant_d  = 4'd0;
      reject_d = 1'b0;
      total_d  = total_q;
      disp_d   = disp_q;
      case (state_q)
         S_IDLE: begin
            if (bus.mode) begin
               state_d = S_RESULTS;
               cnt_d   = '0;
               disp_d  = 2'd0;
            end else if (bus.officer_arm) begin
               state_d = S_ARMED;
               cnt_d   = '0;
            end
         end
         S_ARMED: begin
            if (single_press) begin
               state_d = S_GRANT;
               grant_d = bus.valid_vote;
               total_d = (total_q == 8'hFF) ? total_q : total_q + 8'd1;
            end else if (multi_press) begin
               state_d  = S_IDLE;
               reject_d = 1'b1;
            end else if (bus.mode || cnt_q == ARM_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GRANT: begin
            state_d = S_LOCKOUT;
            cnt_d   = '0;
         end
         S_LOCKOUT: begin
            if (cnt_q == LOCK_LAST) state_d = S_IDLE;
            else                    cnt_d   = cnt_q + 1'b1;
         end
         S_RESULTS: begin
            // Leaving results keeps disp_sel where the scan stopped
            if (!bus.mode) begin
               state_d = S_IDLE;
            end else if (cnt_q == DISP_LAST) begin
               cnt_d  = '0;
               disp_d = disp_q + 2'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_ARMED);
      busy_d  = (state_d == S_GRANT) || (state_d == S_LOCKOUT);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         grant_q  <= 4'd0;
         reject_q <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         total_q  <= 8'd0;
         disp_q   <= 2'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         reject_q <= reject_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         total_q  <= total_d;
         disp_q   <= disp_d;
      end
   end

   assign bus.cand_grant  = grant_q;
   assign bus.reject      = reject_q;
   assign bus.voter_ready = ready_q;
   assign bus.busy        = busy_q;
   assign bus.total_votes = total_q;
   assign bus.disp_sel    = disp_q;
endmodule

// File: tb/tb_ballot_session_controller.sv
// Directed bench for ballot_session_controller: a session-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_ballot_session_controller;
   localparam int LOCK = 16;
   localparam int DISP = 8;
   localparam int ATO  = 64;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_fail;

   ballot_session_controller_if bif ();

   ballot_session_controller #(
      .LOCK_CYCLES(LOCK), .DISP_CYCLES(DISP), .ARM_TIMEOUT(ATO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: phase of the session plus how long it has lasted
   // ph: 0 waiting for officer, 1 voter may press, 2 vote taken / buttons locked, 3 result scan
   int         ph;
   int         arm_age;
   int         busy_left;
   int         res_cycles;
   int         e_total;
   int         e_disp;
   logic [3:0] e_grant;
   logic       e_reject;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         ph <= 0; arm_age <= 0; busy_left <= 0; res_cycles <= 0;
         e_total <= 0; e_disp <= 0; e_grant <= 4'd0; e_reject <= 1'b0;
      end else begin
         e_grant  <= 4'd0;
         e_reject <= 1'b0;
         case (ph)
            0: begin
               if (bif.mode) begin
                  ph <= 3; res_cycles <= 0; e_disp <= 0;
               end else if (bif.officer_arm) begin
                  ph <= 1; arm_age <= 1;
               end
            end
            1: begin
               if ($countones(bif.valid_vote) == 1) begin
                  ph <= 2; e_grant <= bif.valid_vote; busy_left <= LOCK + 1;
                  if (e_total < 255) e_total <= e_total + 1;
               end else if ($countones(bif.valid_vote) > 1) begin
                  ph <= 0; e_reject <= 1'b1;
               end else if (bif.mode || arm_age == ATO) begin
                  ph <= 0;
               end else begin
                  arm_age <= arm_age + 1;
               end
            end
            2: begin
               busy_left <= busy_left - 1;
               if (busy_left == 1) ph <= 0;
            end
            default: begin
               if (!bif.mode) ph <= 0;
               else begin
                  res_cycles <= res_cycles + 1;
                  e_disp     <= ((res_cycles + 1) / DISP) % 4;
               end
            end
         endcase
      end
   end

   always @(negedge clock) begin
      chk("cand_grant",  int'(bif.cand_grant),  int'(e_grant));
      chk("reject",      int'(bif.reject),      int'(e_reject));
      chk("voter_ready", int'(bif.voter_ready), (ph == 1) ? 1 : 0);
      chk("busy",        int'(bif.busy),        (ph == 2) ? 1 : 0);
      chk("total_votes", int'(bif.total_votes), e_total);
      chk("disp_sel",    int'(bif.disp_sel),    e_disp);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic arm_pulse();
      bif.officer_arm = 1'b1;
      tick();
      bif.officer_arm = 1'b0;
   endtask

   int bc;
   int gc;
   int rc;
   int samp [40];

   initial begin
      n_cmp = 0; n_fail = 0;
      bif.mode = 1'b0; bif.officer_arm = 1'b0; bif.valid_vote = 4'd0;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) tick();
      chk("reset total_votes", int'(bif.total_votes), 0);
      chk("reset disp_sel",    int'(bif.disp_sel), 0);
      chk("reset busy",        int'(bif.busy), 0);
      reset = 1'b1;
      tick();

      // Legal vote two cycles after arm, with extra presses during lockout
      arm_pulse();
      tick();
      bif.valid_vote = 4'b0100;
      tick();
      bif.valid_vote = 4'd0;
      chk("vote grant value", int'(bif.cand_grant), 4);
      chk("vote ready drop",  int'(bif.voter_ready), 0);
      chk("vote total",       int'(bif.total_votes), 1);
      bc = 0; gc = 0;
      for (int i = 0; i < 40; i++) begin
         if (bif.busy) bc++;
         if (bif.cand_grant != 4'd0) gc++;
         bif.valid_vote = (i >= 2 && i < 12) ? 4'b0001 : 4'd0;
         tick();
      end
      bif.valid_vote = 4'd0;
      chk("busy length", bc, 17);
      chk("single grant", gc, 1);
      chk("total after lockout presses", int'(bif.total_votes), 1);

      // Two buttons in one cycle
      arm_pulse();
      bif.valid_vote = 4'b0011;
      tick();
      bif.valid_vote = 4'd0;
      chk("reject pulse", int'(bif.reject), 1);
      chk("reject no grant", int'(bif.cand_grant), 0);
      chk("reject total", int'(bif.total_votes), 1);
      tick();
      chk("reject one cycle", int'(bif.reject), 0);

      // Presses with no arm
      for (int b = 0; b < 4; b++) begin
         bif.valid_vote = 4'(1 << b);
         tick();
         bif.valid_vote = 4'd0;
         tick();
      end
      chk("unarmed total", int'(bif.total_votes), 1);

      // Arm timeout, late press
      arm_pulse();
      rc = 0;
      for (int i = 0; i < 80; i++) begin
         if (bif.voter_ready) rc++;
         tick();
      end
      chk("armed window", rc, 64);
      bif.valid_vote = 4'b0010;
      tick();
      bif.valid_vote = 4'd0;
      tick();
      chk("late press total", int'(bif.total_votes), 1);

      // mode raised while armed: back to idle first, results next
      arm_pulse();
      bif.mode = 1'b1;
      tick();
      chk("mode abort ready", int'(bif.voter_ready), 0);
      chk("mode abort reject", int'(bif.reject), 0);
      bif.mode = 1'b0;
      tick();

      // Result scan
      bif.mode = 1'b1;
      tick();
      for (int i = 0; i < 40; i++) begin
         samp[i] = int'(bif.disp_sel);
         bif.valid_vote = (i % 5 == 0) ? 4'b0001 : 4'd0;
         bif.officer_arm = (i == 20);
         tick();
      end
      bif.valid_vote = 4'd0; bif.officer_arm = 1'b0;
      chk("scan 0",  samp[0], 0);
      chk("scan 7",  samp[7], 0);
      chk("scan 8",  samp[8], 1);
      chk("scan 16", samp[16], 2);
      chk("scan 24", samp[24], 3);
      chk("scan 32", samp[32], 0);
      bif.mode = 1'b0;
      tick();
      chk("scan hold", int'(bif.disp_sel), 1);
      bif.valid_vote = 4'b1000;
      tick();
      bif.valid_vote = 4'd0;
      tick();
      chk("post-results press", int'(bif.total_votes), 1);

      // Saturation over 256 sessions
      for (int s = 0; s < 256; s++) begin
         arm_pulse();
         bif.valid_vote = 4'(1 << (s % 4));
         tick();
         bif.valid_vote = 4'd0;
         repeat (LOCK + 1) tick();
      end
      chk("saturated total", int'(bif.total_votes), 255);

      // Reset during lockout
      arm_pulse();
      bif.valid_vote = 4'b1000;
      tick();
      bif.valid_vote = 4'd0;
      repeat (4) tick();
      chk("pre-reset busy", int'(bif.busy), 1);
      reset = 1'b0;
      #1;
      chk("async busy",  int'(bif.busy), 0);
      chk("async total", int'(bif.total_votes), 0);
      chk("async grant", int'(bif.cand_grant), 0);
      chk("async ready", int'(bif.voter_ready), 0);
      chk("async disp",  int'(bif.disp_sel), 0);
      tick();
      reset = 1'b1;
      repeat (3) tick();
      chk("idle after reset", int'(bif.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/ballot_session_controller.md
Name: ballot_session_controller

Overview:
- Sequences one voter session at a time between the per-button debouncers and the vote logger.
- A polling officer arms the machine for exactly one voter. The block accepts that voter's first press and issues a single one-hot grant to the logger, then locks the buttons out for a fixed time.
- In result mode it time-multiplexes the candidate selection for the LED display.

Parameters:
LOCK_CYCLES, 16, post-vote lockout length in clock cycles (>=2)
DISP_CYCLES, 8, cycles each candidate stays selected during result scan (>=1)
ARM_TIMEOUT, 64, cycles an armed session waits for a press before expiring (>=1)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
mode  input  1  0 = voting, 1 = results
officer_arm  input  1  one-cycle pulse; authorises one voter
valid_vote  input  4  bit i = single-cycle debounced press of candidate i+1
cand_grant  output  4  one-hot, one-cycle vote strobe to the logger
voter_ready  output  1  high while ARMED
busy  output  1  high in GRANT or LOCKOUT
reject  output  1  one-cycle pulse on a rejected ballot
total_votes  output  8  granted votes since reset, saturating at 255
disp_sel  output  2  candidate index shown in result mode

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; cand_grant=0; voter_ready=0; busy=0; reject=0; total_votes=0; disp_sel=0; all counters=0.
- States: IDLE, ARMED, GRANT, LOCKOUT, RESULTS. All outputs are registered.
- IDLE:
  - mode=1 -> RESULTS.
  - mode=0 and officer_arm=1 -> ARMED; timeout counter cleared.
  - valid_vote is ignored.
- ARMED (voter_ready=1):
  - Exactly one valid_vote bit set -> GRANT. The press is latched.
  - Two or more bits set in the same cycle -> reject pulse for one cycle, then IDLE. No grant.
  - mode=1 -> IDLE. No grant, no reject. RESULTS is entered on the following cycle.
  - Timeout counter reaches ARM_TIMEOUT-1 with no press -> IDLE.
  - officer_arm while ARMED has no effect.
- GRANT (one cycle):
  - cand_grant = the latched one-hot value; busy=1.
  - total_votes increments unless it is already 255.
  - Next state is LOCKOUT.
- LOCKOUT:
  - busy=1; counts LOCK_CYCLES cycles, then -> IDLE.
  - All presses and officer_arm are ignored.
  - mode=1 does not abort LOCKOUT; it is honoured from IDLE.
- Latency: a press in ARMED at cycle N gives cand_grant at cycle N+1. voter_ready drops at N+1.
- RESULTS:
  - disp_sel starts at 0 and advances every DISP_CYCLES cycles: 0,1,2,3,0,... (2-bit wrap).
  - mode=0 -> IDLE; disp_sel is held at its last value.
  - Presses and officer_arm are ignored in RESULTS.
- Invariants:
  - cand_grant is never non-zero for more than one consecutive cycle.
  - At most one grant per officer_arm.
- Reset asserted mid-session aborts immediately. No partial grant is issued.

Test Plan:
- Reset, mode=0, officer_arm pulse, valid_vote=0100 two cycles later -> cand_grant=0100 for exactly 1 cycle; total_votes=1; busy high 1+16 cycles; then IDLE.
- Armed, valid_vote=0011 in one cycle -> reject=1 for 1 cycle; cand_grant stays 0; total_votes unchanged; state IDLE.
- No arm, valid_vote pulses on every bit -> no grant; extra presses during LOCKOUT after a legal vote -> no additional grant.
- Arm, then no press for 64 cycles -> voter_ready falls at cycle 64; a later press gives no grant.
- mode=1 for 40 cycles -> disp_sel sequence 0,1,2,3,0, each held 8 cycles; mode=0 -> IDLE; buttons are ignored until the next arm.
- 256 arm+vote sessions -> total_votes saturates at 255.
- reset asserted during LOCKOUT -> all outputs are 0 asynchronously.
